// File: rtl/pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_pkg
// Description : Shared definitions for the pattern-generator bank: tile mode
//               and scroll direction encodings, plus the default colours that
//               the scrolling generators come out of reset with.
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_pkg;

    typedef enum logic [1:0] {
        MODE_CHECKER = 2'd0,
        MODE_VSTRIPE = 2'd1,
        MODE_HSTRIPE = 2'd2,
        MODE_DIAG    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        DIR_POS_X = 2'd0,
        DIR_NEG_X = 2'd1,
        DIR_POS_Y = 2'd2,
        DIR_DIAG  = 2'd3
    } dir_e;

    localparam logic [5:0] DEFAULT_FG = 6'b100100;
    localparam logic [5:0] DEFAULT_BG = 6'b000000;

endpackage : pattern_pkg
`default_nettype wire

// File: rtl/fixed_step_accum.sv
`default_nettype none
// ============================================================================
// Module      : fixed_step_accum
// Description : Fixed-point subpixel step accumulator. Holds the fractional
//               remainder and, for the current step_size, presents the whole
//               pixel advance that an update strobe commits.
// Ports       : clk, rst_n       - clock, async active-low reset
//               update_i         - commit strobe (frac advances this clk)
//               step_size_i      - unsigned {int, frac} px/frame
//               adv_o            - whole-pixel advance for this update
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_step_accum #(
    parameter int FRAC_W = 2,
    parameter int STEP_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     update_i,
    input  logic [STEP_W-1:0]        step_size_i,
    output logic [STEP_W-FRAC_W:0]   adv_o
);

    localparam int INT_W = STEP_W - FRAC_W;

    logic [FRAC_W-1:0] frac_q;
    logic [FRAC_W-1:0] frac_d;
    logic [FRAC_W:0]   fsum;

    always_comb begin
        fsum   = {1'b0, frac_q} + {1'b0, step_size_i[FRAC_W-1:0]};
        // Integer part plus the carry out of the fractional sum.
        adv_o  = {1'b0, step_size_i[STEP_W-1:FRAC_W]} + {{INT_W{1'b0}}, fsum[FRAC_W]};
        frac_d = update_i ? fsum[FRAC_W-1:0] : frac_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frac_q <= '0;
        end else begin
            frac_q <= frac_d;
        end
    end

endmodule : fixed_step_accum
`default_nettype wire

// File: rtl/scroll_tile_gen.sv
`default_nettype none
// ============================================================================
// Module      : scroll_tile_gen
// Description : Scrolling tile pattern generator. Tiles of 2**TILE_LOG2 px are
//               offset by a fixed-point per-frame step in one of four
//               directions; mode/direction/colours are shadowed at the frame
//               boundary so a frame never tears.
// Ports       : clk, rst_n          - pixel clock, async active-low reset
//               pattern_enable     - generator selected (else rgb=0, hold)
//               x, y, active       - pixel coordinate and visible flag
//               next_frame         - frame pulse: offsets/config update point
//               step_size, pause   - scroll speed {int,frac}, scroll freeze
//               mode_in, dir_in    - tile mode and scroll direction
//               fg_in, bg_in       - tile-set / tile-clear colours
//               rgb                - registered pixel colour (1 clk latency)
//               wrap               - one-clk pulse when an offset wrapped
// Revision    : 1.0 - initial release
// ============================================================================
module scroll_tile_gen
    import pattern_pkg::*;
#(
    parameter int COORD_W   = 10,
    parameter int TILE_LOG2 = 5,
    parameter int FRAC_W    = 2,
    parameter int STEP_W    = 3,
    parameter int COLOR_W   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pattern_enable,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               active,
    input  logic               next_frame,
    input  logic [STEP_W-1:0]  step_size,
    input  logic               pause,
    input  logic [1:0]         mode_in,
    input  logic [1:0]         dir_in,
    input  logic [COLOR_W-1:0] fg_in,
    input  logic [COLOR_W-1:0] bg_in,
    output logic [COLOR_W-1:0] rgb,
    output logic               wrap
);

    localparam int ADV_W = STEP_W - FRAC_W + 1;

    // Offsets and wrap flag
    logic [COORD_W-1:0] off_x_q, off_x_d;
    logic [COORD_W-1:0] off_y_q, off_y_d;
    logic               wrap_q,  wrap_d;
    // Frame-boundary config shadows
    mode_e              mode_q,  mode_d;
    dir_e               dir_q,   dir_d;
    logic [COLOR_W-1:0] fg_q,    fg_d;
    logic [COLOR_W-1:0] bg_q,    bg_d;
    // Pixel output
    logic [COLOR_W-1:0] rgb_q,   rgb_d;

    logic               frame_upd;
    logic               advance;
    logic [ADV_W-1:0]   adv;
    logic [COORD_W:0]   adv_ext;
    logic [COORD_W:0]   x_inc, x_dec, y_inc;
    logic [COORD_W-1:0] sx, sy, sd;
    logic               sel;

    assign frame_upd = pattern_enable && next_frame;
    assign advance   = frame_upd && !pause;

    fixed_step_accum #(
        .FRAC_W (FRAC_W),
        .STEP_W (STEP_W)
    ) u_accum (
        .clk         (clk),
        .rst_n       (rst_n),
        .update_i    (advance),
        .step_size_i (step_size),
        .adv_o       (adv)
    );

    // One extra MSB captures the add carry / subtract borrow used for wrap.
    assign adv_ext = (COORD_W+1)'(adv);
    assign x_inc   = {1'b0, off_x_q} + adv_ext;
    assign x_dec   = {1'b0, off_x_q} - adv_ext;
    assign y_inc   = {1'b0, off_y_q} + adv_ext;

    // Offset advance uses dir_q, i.e. the direction held before this edge.
    always_comb begin
        off_x_d = off_x_q;
        off_y_d = off_y_q;
        wrap_d  = 1'b0;
        if (advance) begin
            case (dir_q)
                DIR_POS_X: begin
                    off_x_d = x_inc[COORD_W-1:0];
                    wrap_d  = x_inc[COORD_W];
                end
                DIR_NEG_X: begin
                    off_x_d = x_dec[COORD_W-1:0];
                    wrap_d  = x_dec[COORD_W];
                end
                DIR_POS_Y: begin
                    off_y_d = y_inc[COORD_W-1:0];
                    wrap_d  = y_inc[COORD_W];
                end
                default: begin
                    off_x_d = x_inc[COORD_W-1:0];
                    off_y_d = y_inc[COORD_W-1:0];
                    wrap_d  = x_inc[COORD_W] | y_inc[COORD_W];
                end
            endcase
        end
    end

    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        fg_d   = fg_q;
        bg_d   = bg_q;
        if (frame_upd) begin
            mode_d = mode_e'(mode_in);
            dir_d  = dir_e'(dir_in);
            fg_d   = fg_in;
            bg_d   = bg_in;
        end
    end

    // Pixel path: scrolled coordinate, tile select bit, colour.
    always_comb begin
        sx  = x + off_x_q;
        sy  = y + off_y_q;
        sd  = sx + sy;
        sel = 1'b0;
        case (mode_q)
            MODE_CHECKER: sel = sx[TILE_LOG2] ^ sy[TILE_LOG2];
            MODE_VSTRIPE: sel = sx[TILE_LOG2];
            MODE_HSTRIPE: sel = sy[TILE_LOG2];
            default:      sel = sd[TILE_LOG2];
        endcase
        rgb_d = '0;
        if (pattern_enable && active) begin
            rgb_d = sel ? fg_q : bg_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_x_q <= '0;
            off_y_q <= '0;
            wrap_q  <= 1'b0;
            mode_q  <= MODE_CHECKER;
            dir_q   <= DIR_POS_X;
            fg_q    <= COLOR_W'(DEFAULT_FG);
            bg_q    <= COLOR_W'(DEFAULT_BG);
            rgb_q   <= '0;
        end else begin
            off_x_q <= off_x_d;
            off_y_q <= off_y_d;
            wrap_q  <= wrap_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            rgb_q   <= rgb_d;
        end
    end

    assign rgb  = rgb_q;
    assign wrap = wrap_q;

endmodule : scroll_tile_gen
`default_nettype wire
